// File: rtl/neuron_output_stage_if.sv
// Handshake bundle between the dot-product stage, the output stage and its consumers.
// The output stage takes the slave view; the upstream/consumer side takes the master view.
interface neuron_output_stage_if #(
    parameter int NUM_CLASSES = 10,
    parameter int VALUE_WIDTH = 26,
    parameter int IDX_WIDTH   = 4
);
    logic signed [VALUE_WIDTH-1:0]             value;
    logic                                      value_valid;
    logic        [NUM_CLASSES*VALUE_WIDTH-1:0] Biases;
    logic                                      frame_clear;
    logic        [VALUE_WIDTH-1:0]             act_out;
    logic        [IDX_WIDTH-1:0]               act_idx;
    logic                                      act_valid;
    logic        [IDX_WIDTH-1:0]               class_out;
    logic        [VALUE_WIDTH-1:0]             max_out;
    logic                                      result_valid;
    logic                                      busy;

    modport master (
        output value, value_valid, Biases, frame_clear,
        input  act_out, act_idx, act_valid, class_out, max_out, result_valid, busy
    );

    modport slave (
        input  value, value_valid, Biases, frame_clear,
        output act_out, act_idx, act_valid, class_out, max_out, result_valid, busy
    );
endinterface

// File: rtl/neuron_output_stage.sv
// Per-neuron saturating bias add, ReLU and frame-wide argmax. Two-stage pipeline,
// one neuron per cycle, with the per-neuron activations streamed out alongside.
//
// state   | meaning
// IDLE    | no partial frame; next accepted value is class 0
// COLLECT | partial frame in progress, in_idx is the next class to accept
module neuron_output_stage #(
    parameter int NUM_CLASSES = 10,
    parameter int VALUE_WIDTH = 26,
    parameter int IDX_WIDTH   = 4
) (
    input logic                 clk,
    input logic                 GlobalReset,
    neuron_output_stage_if.slave bus
);
    localparam int W = VALUE_WIDTH;
    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_CLASSES - 1);
    localparam logic [W-1:0] SAT_MAX = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] SAT_MIN = {1'b1, {(W-1){1'b0}}};

    typedef enum logic {IDLE, COLLECT} state_t;

    state_t               state;
    logic [IDX_WIDTH-1:0] in_idx;
    logic                 busy_r;
    logic                 accept;

    logic [W-1:0]         bias_arr [NUM_CLASSES];
    logic [W-1:0]         bias_sel;
    logic [W:0]           sum_full;
    logic [W-1:0]         sum_sat;

    logic [W-1:0]         s1_sum;
    logic [IDX_WIDTH-1:0] s1_idx;
    logic                 s1_valid;

    logic [W-1:0]         act_c;
    logic                 take;
    logic [W-1:0]         win_val;
    logic [IDX_WIDTH-1:0] win_idx;
    logic [W-1:0]         max_val;
    logic [IDX_WIDTH-1:0] max_idx;

    logic [W-1:0]         act_out_r;
    logic [IDX_WIDTH-1:0] act_idx_r;
    logic                 act_valid_r;
    logic [IDX_WIDTH-1:0] class_out_r;
    logic [W-1:0]         max_out_r;
    logic                 result_valid_r;

    // Clear wins over a coincident strobe, so the value is simply not accepted.
    assign accept = bus.value_valid && !bus.frame_clear;

    for (genvar k = 0; k < NUM_CLASSES; k++) begin : g_bias
        assign bias_arr[k] = bus.Biases[k*W +: W];
    end

    assign bias_sel = bias_arr[in_idx];
    assign sum_full = {bus.value[W-1], bus.value} + {bias_sel[W-1], bias_sel};

    always_comb begin
        sum_sat = sum_full[W-1:0];
        if (sum_full[W] != sum_full[W-1]) begin
            sum_sat = sum_full[W] ? SAT_MIN : SAT_MAX;
        end
    end

    always_ff @(posedge clk or negedge GlobalReset) begin
        if (!GlobalReset) begin
            state  <= IDLE;
            in_idx <= '0;
            busy_r <= 1'b0;
        end else if (bus.frame_clear) begin
            state  <= IDLE;
            in_idx <= '0;
            busy_r <= 1'b0;
        end else if (bus.value_valid) begin
            case (state)
                IDLE: begin
                    state  <= COLLECT;
                    busy_r <= 1'b1;
                    in_idx <= in_idx + 1'b1;
                end
                COLLECT: begin
                    if (in_idx == LAST_IDX) begin
                        state  <= IDLE;
                        busy_r <= 1'b0;
                        in_idx <= '0;
                    end else begin
                        in_idx <= in_idx + 1'b1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_r <= 1'b0;
                    in_idx <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge GlobalReset) begin
        if (!GlobalReset) begin
            s1_sum   <= '0;
            s1_idx   <= '0;
            s1_valid <= 1'b0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_sum <= sum_sat;
                s1_idx <= in_idx;
            end
        end
    end

    // Activations are non-negative, so an unsigned compare orders them correctly.
    assign act_c   = s1_sum[W-1] ? '0 : s1_sum;
    assign take    = (s1_idx == '0) || (act_c > max_val);
    assign win_val = take ? act_c : max_val;
    assign win_idx = take ? s1_idx : max_idx;

    always_ff @(posedge clk or negedge GlobalReset) begin
        if (!GlobalReset) begin
            act_out_r      <= '0;
            act_idx_r      <= '0;
            act_valid_r    <= 1'b0;
            max_val        <= '0;
            max_idx        <= '0;
            class_out_r    <= '0;
            max_out_r      <= '0;
            result_valid_r <= 1'b0;
        end else begin
            result_valid_r <= 1'b0;
            act_valid_r    <= s1_valid && !bus.frame_clear;
            if (s1_valid) begin
                act_out_r <= act_c;
                act_idx_r <= s1_idx;
            end
            if (s1_valid && !bus.frame_clear) begin
                max_val <= win_val;
                max_idx <= win_idx;
                if (s1_idx == LAST_IDX) begin
                    class_out_r    <= win_idx;
                    max_out_r      <= win_val;
                    result_valid_r <= 1'b1;
                end
            end
        end
    end

    assign bus.act_out      = act_out_r;
    assign bus.act_idx      = act_idx_r;
    assign bus.act_valid    = act_valid_r;
    assign bus.class_out    = class_out_r;
    assign bus.max_out      = max_out_r;
    assign bus.result_valid = result_valid_r;
    assign bus.busy         = busy_r;
endmodule

// File: tb/tb_neuron_output_stage.sv
// Bench for neuron_output_stage: directed frames feed an expectation queue that a
// negedge monitor drains whenever act_valid or result_valid appears.
module tb_neuron_output_stage;
    logic clk;
    logic GlobalReset;
    int   cyc;
    int   errors;
    int   checks;
    int   tb_idx;

    typedef struct {
        logic [25:0] act;
        logic [3:0]  idx;
        int          at;
    } act_exp_t;

    typedef struct {
        logic [3:0]  cls;
        logic [25:0] mx;
        int          at;
    } res_exp_t;

    act_exp_t act_q[$];
    res_exp_t res_q[$];

    neuron_output_stage_if #(.NUM_CLASSES(10), .VALUE_WIDTH(26), .IDX_WIDTH(4)) bus ();

    neuron_output_stage #(.NUM_CLASSES(10), .VALUE_WIDTH(26), .IDX_WIDTH(4)) dut (
        .clk        (clk),
        .GlobalReset(GlobalReset),
        .bus        (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (GlobalReset) begin
            if (bus.act_valid) begin
                checks++;
                if (act_q.size() == 0) begin
                    errors++;
                    $display("FAIL act_unexpected: got act=%h idx=%0d at cyc %0d, required no strobe",
                             bus.act_out, bus.act_idx, cyc);
                end else begin
                    act_exp_t e;
                    e = act_q.pop_front();
                    if (bus.act_out !== e.act || bus.act_idx !== e.idx || cyc != e.at) begin
                        errors++;
                        $display("FAIL act: got act=%h idx=%0d cyc=%0d, required act=%h idx=%0d cyc=%0d",
                                 bus.act_out, bus.act_idx, cyc, e.act, e.idx, e.at);
                    end
                end
            end
            if (bus.result_valid) begin
                checks++;
                if (res_q.size() == 0) begin
                    errors++;
                    $display("FAIL result_unexpected: got class=%0d max=%h at cyc %0d, required no strobe",
                             bus.class_out, bus.max_out, cyc);
                end else begin
                    res_exp_t r;
                    r = res_q.pop_front();
                    if (bus.class_out !== r.cls || bus.max_out !== r.mx || cyc != r.at) begin
                        errors++;
                        $display("FAIL result: got class=%0d max=%h cyc=%0d, required class=%0d max=%h cyc=%0d",
                                 bus.class_out, bus.max_out, cyc, r.cls, r.mx, r.at);
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, got, req);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [25:0] v, input logic [25:0] exp_act, input bit chk);
        act_exp_t e;
        bus.value       = v;
        bus.value_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.value_valid = 1'b0;
        if (chk) begin
            e.act = exp_act;
            e.idx = 4'(tb_idx);
            e.at  = cyc + 1;
            act_q.push_back(e);
        end
        tb_idx = (tb_idx == 9) ? 0 : tb_idx + 1;
    endtask

    task automatic expect_res(input logic [3:0] cls, input logic [25:0] mx);
        res_exp_t r;
        r.cls = cls;
        r.mx  = mx;
        r.at  = cyc + 1;
        res_q.push_back(r);
    endtask

    task automatic set_bias(input int k, input logic [25:0] b);
        bus.Biases[k*26 +: 26] = b;
    endtask

    task automatic clear_pulse(input bit with_value);
        bus.frame_clear = 1'b1;
        bus.value       = 26'd999;
        bus.value_valid = with_value;
        @(posedge clk);
        #1;
        bus.frame_clear = 1'b0;
        bus.value_valid = 1'b0;
        tb_idx = 0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_act_out"},      32'(bus.act_out),      32'd0);
        check({tag, "_act_idx"},      32'(bus.act_idx),      32'd0);
        check({tag, "_act_valid"},    32'(bus.act_valid),    32'd0);
        check({tag, "_class_out"},    32'(bus.class_out),    32'd0);
        check({tag, "_max_out"},      32'(bus.max_out),      32'd0);
        check({tag, "_result_valid"}, 32'(bus.result_valid), 32'd0);
        check({tag, "_busy"},         32'(bus.busy),         32'd0);
    endtask

    initial begin
        errors          = 0;
        checks          = 0;
        tb_idx          = 0;
        GlobalReset     = 1'b0;
        bus.value       = '0;
        bus.value_valid = 1'b0;
        bus.frame_clear = 1'b0;
        bus.Biases      = '0;

        // Strobes during reset must have no effect.
        bus.value = 26'd5;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            bus.value_valid = ~bus.value_valid;
        end
        bus.value_valid = 1'b0;
        check_all_zero("reset");
        GlobalReset = 1'b1;
        idle(1);

        // Ramp 0..9, zero biases.
        for (int k = 0; k < 10; k++) begin
            send(26'(k), 26'(k), 1'b1);
            if (k == 4) check("busy_mid_frame", 32'(bus.busy), 32'd1);
        end
        expect_res(4'd9, 26'd9);
        check("busy_after_frame", 32'(bus.busy), 32'd0);
        idle(4);

        // Saturation high, saturation low, plain negative and plain positive bias.
        set_bias(3, 26'h0000100);
        set_bias(5, 26'h3FFFFFF);
        set_bias(7, 26'h3FFFFCE);
        set_bias(8, 26'h0000020);
        for (int k = 0; k < 10; k++) begin
            case (k)
                3:       send(26'h1FFFFF0, 26'h1FFFFFF, 1'b1);
                5:       send(26'h2000000, 26'h0000000, 1'b1);
                7:       send(26'd40,      26'd0,       1'b1);
                8:       send(26'h10,      26'h30,      1'b1);
                default: send(26'(10*k),   26'(10*k),   1'b1);
            endcase
        end
        expect_res(4'd3, 26'h1FFFFFF);
        bus.Biases = '0;
        idle(4);

        // Tie at 500 between classes 2 and 7.
        for (int k = 0; k < 10; k++) begin
            if (k == 2 || k == 7) send(26'd500, 26'd500, 1'b1);
            else                  send(26'd100, 26'd100, 1'b1);
        end
        expect_res(4'd2, 26'd500);
        idle(4);

        // All negative.
        for (int k = 0; k < 10; k++) send(26'h3FFFC18, 26'd0, 1'b1);
        expect_res(4'd0, 26'd0);
        idle(4);

        // Abort after 5 values, then a full frame peaking at class 4.
        for (int k = 0; k < 5; k++) send(26'(200 + k), 26'(200 + k), 1'b1);
        idle(3);
        clear_pulse(1'b0);
        check("busy_after_clear", 32'(bus.busy), 32'd0);
        for (int k = 0; k < 10; k++) begin
            if (k == 4) send(26'd77, 26'd77, 1'b1);
            else        send(26'(k), 26'(k), 1'b1);
        end
        expect_res(4'd4, 26'd77);
        idle(4);

        // Clear coincident with a strobe; the value in stage 1 is killed too.
        send(26'd300, 26'd300, 1'b1);
        send(26'd301, 26'd301, 1'b1);
        send(26'd302, 26'd302, 1'b0);
        clear_pulse(1'b1);
        check("busy_after_coincident_clear", 32'(bus.busy), 32'd0);
        for (int k = 0; k < 10; k++) begin
            if (k == 6) send(26'd300, 26'd300, 1'b1);
            else        send(26'(20 + k), 26'(20 + k), 1'b1);
        end
        expect_res(4'd6, 26'd300);
        idle(4);

        // Back-to-back frames, peaks at class 1 then class 8.
        for (int n = 0; n < 20; n++) begin
            if (n == 1)       send(26'd60, 26'd60, 1'b1);
            else if (n == 18) send(26'd80, 26'd80, 1'b1);
            else              send(26'd5,  26'd5,  1'b1);
            if (n == 9)  expect_res(4'd1, 26'd60);
            if (n == 19) expect_res(4'd8, 26'd80);
        end
        idle(4);

        // Reset mid-frame clears everything immediately.
        for (int k = 0; k < 3; k++) send(26'(40 + k), 26'(40 + k), 1'b1);
        idle(3);
        check("busy_before_reset", 32'(bus.busy), 32'd1);
        check("class_before_reset", 32'(bus.class_out), 32'd8);
        #2;
        GlobalReset = 1'b0;
        #1;
        check_all_zero("async_reset");
        idle(2);
        GlobalReset = 1'b1;
        tb_idx = 0;
        idle(4);

        check("act_queue_drained", 32'(act_q.size()), 32'd0);
        check("result_queue_drained", 32'(res_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL timeout: got no completion by 200000, required completion");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "timeout");
    end
endmodule
